// File: rtl/sysctl_regbank.sv
// Byte-wide system-control register bank with a one-cycle-deferred CPU write commit and sticky hardware set bits.
// Optional write-one-to-clear bits are enabled by defining SYSCTL_REGBANK_W1C_EN.
module sysctl_regbank #(
    parameter int                     NUM_REGS    = 3,
    parameter logic [23:0]            BASE_ADDR   = 24'h2000,
    parameter logic [NUM_REGS*8-1:0]  RESET_VALUE = '0,
    parameter logic [NUM_REGS*8-1:0]  W1C_MASK    = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clk_ce,
    input  logic                    bus_write,
    input  logic [23:0]             bus_address_in,
    input  logic [7:0]              bus_data_in,
    output logic [7:0]              bus_data_out,
    input  logic [NUM_REGS*8-1:0]   hw_set,
    output logic [NUM_REGS*8-1:0]   regs_out,
    output logic [NUM_REGS-1:0]     write_pulse
);

    localparam logic [23:0] LAST_ADDR = 24'(BASE_ADDR + NUM_REGS - 1);

    logic [NUM_REGS-1:0][7:0] regs_q, regs_d;
    logic                     write_pending_q;
    logic                     addr_hit;
    logic [3:0]               addr_idx;
    logic                     commit;

    assign addr_hit = (bus_address_in >= BASE_ADDR) && (bus_address_in <= LAST_ADDR);
    assign addr_idx = 4'(bus_address_in - BASE_ADDR);
    // Reset pre-empts a commit that would otherwise land on this edge.
    assign commit   = clk_ce && write_pending_q && !reset && addr_hit;
    assign regs_out = regs_q;

`ifndef SYSCTL_REGBANK_W1C_EN
    logic unused_w1c;
    assign unused_w1c = ^W1C_MASK;
`endif

    always_comb begin
        bus_data_out = 8'h00;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr_hit && addr_idx == 4'(i))
                bus_data_out = regs_q[i];
        end
    end

    always_comb begin
        regs_d      = regs_q;
        write_pulse = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (commit && addr_idx == 4'(i)) begin
                write_pulse[i] = 1'b1;
`ifdef SYSCTL_REGBANK_W1C_EN
                // Masked bits: a written 1 clears, a written 0 holds.
                regs_d[i] = (regs_q[i] & ~bus_data_in & W1C_MASK[i*8 +: 8])
                          | (bus_data_in & ~W1C_MASK[i*8 +: 8]);
`else
                regs_d[i] = bus_data_in;
`endif
            end
            regs_d[i] = regs_d[i] | hw_set[i*8 +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q          <= RESET_VALUE;
            write_pending_q <= 1'b0;
        end else if (clk_ce) begin
            regs_q          <= regs_d;
            write_pending_q <= bus_write;
        end
    end

endmodule

// File: tb/tb_sysctl_regbank.sv
// Directed bench for sysctl_regbank: reset, deferred commit, hw_set priority, miss, back-to-back, ce hold, W1C, reset kill.
module tb_sysctl_regbank;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clk_ce = 1'b0;
    logic        bus_write = 1'b0;
    logic [23:0] bus_address_in = 24'h0;
    logic [7:0]  bus_data_in = 8'h0;
    logic [7:0]  bus_data_out;
    logic [23:0] hw_set = 24'h0;
    logic [23:0] regs_out;
    logic [2:0]  write_pulse;

    int tests = 0;
    int fails = 0;

    sysctl_regbank #(
        .NUM_REGS(3),
        .BASE_ADDR(24'h2000),
        .RESET_VALUE(24'h000000),
        .W1C_MASK(24'h0000FF)
    ) dut (
        .clk(clk), .reset(reset), .clk_ce(clk_ce), .bus_write(bus_write),
        .bus_address_in(bus_address_in), .bus_data_in(bus_data_in),
        .bus_data_out(bus_data_out), .hw_set(hw_set), .regs_out(regs_out),
        .write_pulse(write_pulse)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; clk_ce = 1'b0;
        tick();
        reset = 1'b0;
        #2;
        tests++;
        if (regs_out !== 24'h0) begin
            fails++; $display("FAIL reset_regs got=%h exp=%h", regs_out, 24'h0);
        end
        tests++;
        if (write_pulse !== 3'b000) begin
            fails++; $display("FAIL reset_pulse got=%b exp=%b", write_pulse, 3'b000);
        end
        for (int a = 0; a < 4; a++) begin
            bus_address_in = 24'h2000 + 24'(a);
            #1;
            tests++;
            if (bus_data_out !== 8'h00) begin
                fails++; $display("FAIL reset_read addr=%h got=%h exp=%h", bus_address_in, bus_data_out, 8'h00);
            end
        end
    endtask

    task automatic test_write();
        clk_ce = 1'b1; bus_write = 1'b1; bus_address_in = 24'h2001; bus_data_in = 8'hA5;
        tick();
        bus_write = 1'b0;
        #2;
        tests++;
        if (write_pulse !== 3'b010 || regs_out !== 24'h000000) begin
            fails++; $display("FAIL write_commit_cycle pulse=%b regs=%h exp pulse=010 regs=000000", write_pulse, regs_out);
        end
        tick();
        #2;
        tests++;
        if (regs_out !== 24'h00A500) begin
            fails++; $display("FAIL write_result got=%h exp=%h", regs_out, 24'h00A500);
        end
        tests++;
        if (write_pulse !== 3'b000) begin
            fails++; $display("FAIL write_pulse_width got=%b exp=%b", write_pulse, 3'b000);
        end
        tests++;
        if (bus_data_out !== 8'hA5) begin
            fails++; $display("FAIL write_readback got=%h exp=%h", bus_data_out, 8'hA5);
        end
    endtask

    task automatic test_hwset_priority();
        bus_write = 1'b1; bus_address_in = 24'h2002; bus_data_in = 8'h00;
        tick();
        bus_write = 1'b0; hw_set = 24'h1 << 17;
        tick();
        hw_set = 24'h0;
        #2;
        tests++;
        if (regs_out !== 24'h02A500) begin
            fails++; $display("FAIL hwset_wins got=%h exp=%h", regs_out, 24'h02A500);
        end
    endtask

    task automatic test_miss();
        logic [23:0] miss_addr [2];
        miss_addr[0] = 24'h2003;
        miss_addr[1] = 24'h1FFF;
        for (int k = 0; k < 2; k++) begin
            bus_write = 1'b1; bus_address_in = miss_addr[k]; bus_data_in = 8'hFF;
            tick();
            bus_write = 1'b0;
            #2;
            tests++;
            if (write_pulse !== 3'b000) begin
                fails++; $display("FAIL miss_pulse addr=%h got=%b exp=000", miss_addr[k], write_pulse);
            end
            tick();
            #2;
            tests++;
            if (regs_out !== 24'h02A500) begin
                fails++; $display("FAIL miss_regs addr=%h got=%h exp=%h", miss_addr[k], regs_out, 24'h02A500);
            end
        end
    endtask

    task automatic test_back_to_back();
        bus_write = 1'b1; bus_address_in = 24'h2001; bus_data_in = 8'h11;
        tick();
        bus_data_in = 8'h22;
        #2;
        tests++;
        if (write_pulse !== 3'b010) begin
            fails++; $display("FAIL b2b_pulse1 got=%b exp=010", write_pulse);
        end
        tick();
        bus_address_in = 24'h2002; bus_data_in = 8'h33;
        #2;
        tests++;
        if (write_pulse !== 3'b100 || regs_out !== 24'h022200) begin
            fails++; $display("FAIL b2b_pulse2 pulse=%b regs=%h exp 100/022200", write_pulse, regs_out);
        end
        tick();
        bus_write = 1'b0; bus_address_in = 24'h2001; bus_data_in = 8'h44;
        #2;
        tests++;
        if (write_pulse !== 3'b010) begin
            fails++; $display("FAIL b2b_trailing_pulse got=%b exp=010", write_pulse);
        end
        tick();
        #2;
        tests++;
        if (write_pulse !== 3'b000 || regs_out !== 24'h334400) begin
            fails++; $display("FAIL b2b_end pulse=%b regs=%h exp 000/334400", write_pulse, regs_out);
        end
    endtask

    task automatic test_ce_hold();
        bus_write = 1'b1; bus_address_in = 24'h2002; bus_data_in = 8'h55;
        tick();
        clk_ce = 1'b0; hw_set = 24'hFFFFFF;
        for (int c = 0; c < 5; c++) begin
            #2;
            tests++;
            if (write_pulse !== 3'b000 || regs_out !== 24'h334400) begin
                fails++; $display("FAIL ce_hold cyc=%0d pulse=%b regs=%h exp 000/334400", c, write_pulse, regs_out);
            end
            tick();
        end
        clk_ce = 1'b1; bus_write = 1'b0; hw_set = 24'h0;
        #2;
        tests++;
        if (write_pulse !== 3'b100) begin
            fails++; $display("FAIL ce_pending_kept got=%b exp=100", write_pulse);
        end
        tick();
        #2;
        tests++;
        if (regs_out !== 24'h554400) begin
            fails++; $display("FAIL ce_resume got=%h exp=%h", regs_out, 24'h554400);
        end
    endtask

    task automatic test_w1c();
        logic [7:0] exp1, exp2;
`ifdef SYSCTL_REGBANK_W1C_EN
        exp1 = 8'hFE; exp2 = 8'hFE;
`else
        exp1 = 8'h01; exp2 = 8'h00;
`endif
        hw_set = 24'h0000FF;
        tick();
        hw_set = 24'h0;
        bus_write = 1'b1; bus_address_in = 24'h2000; bus_data_in = 8'h01;
        tick();
        bus_write = 1'b0;
        tick();
        #2;
        tests++;
        if (regs_out !== {16'h5544, exp1}) begin
            fails++; $display("FAIL w1c_write1 got=%h exp=%h", regs_out, {16'h5544, exp1});
        end
        bus_write = 1'b1; bus_data_in = 8'h00;
        tick();
        bus_write = 1'b0;
        tick();
        #2;
        tests++;
        if (regs_out !== {16'h5544, exp2}) begin
            fails++; $display("FAIL w1c_write0 got=%h exp=%h", regs_out, {16'h5544, exp2});
        end
    endtask

    task automatic test_reset_kill();
        bus_write = 1'b1; bus_address_in = 24'h2001; bus_data_in = 8'h77;
        tick();
        bus_write = 1'b0; reset = 1'b1;
        #2;
        tests++;
        if (write_pulse !== 3'b000) begin
            fails++; $display("FAIL rstkill_pulse got=%b exp=000", write_pulse);
        end
        tick();
        reset = 1'b0;
        #2;
        tests++;
        if (write_pulse !== 3'b000 || regs_out !== 24'h000000) begin
            fails++; $display("FAIL rstkill_after pulse=%b regs=%h exp 000/000000", write_pulse, regs_out);
        end
        tick();
        #2;
        tests++;
        if (regs_out !== 24'h000000 || bus_data_out !== 8'h00) begin
            fails++; $display("FAIL rstkill_hold regs=%h rd=%h exp 000000/00", regs_out, bus_data_out);
        end
    endtask

    initial begin
        tick();
        test_reset();
        test_write();
        test_hwset_priority();
        test_miss();
        test_back_to_back();
        test_ce_hold();
        test_w1c();
        test_reset_kill();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
